// File: rtl/wave_capture_if.sv
// wave_capture_if: sample stream and display read port of the wave capture buffer.
interface wave_capture_if #(
  parameter int unsigned ADDR_W = 10
) ();
  logic [7:0]        wave_data_i;
  logic              wave_data_valid_i;
  logic              frame_done_i;
  logic [ADDR_W-1:0] rd_addr_i;
  logic [7:0]        rd_data_o;

  // Source/display side: drives samples, frame handshake and read address.
  modport master (
    output wave_data_i,
    output wave_data_valid_i,
    output frame_done_i,
    output rd_addr_i,
    input  rd_data_o
  );

  // Capture block side.
  modport slave (
    input  wave_data_i,
    input  wave_data_valid_i,
    input  frame_done_i,
    input  rd_addr_i,
    output rd_data_o
  );
endinterface

// File: rtl/wave_capture.sv
// wave_capture: rising-edge triggered, decimating single-frame capture buffer
// feeding an LCD column display. Optional auto-trigger timeout is enabled by
// defining WAVE_CAP_AUTO_TRIG_EN.
module wave_capture #(
  parameter int unsigned DEPTH    = 1024,
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned AUTO_CNT = 65535
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  wave_capture_if.slave bus,
  input  logic [7:0]    trig_level_i,
  input  logic [7:0]    decim_i,
  output logic          cap_done_o,
  output logic          busy_o,
  output logic          auto_trig_o
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEC_W  = 8;

  localparam logic [1:0] ST_WAIT_TRIG = 2'd0;
  localparam logic [1:0] ST_CAPTURE   = 2'd1;
  localparam logic [1:0] ST_HOLD      = 2'd2;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  // Reject inconsistent buffer geometry or a zero timeout at elaboration.
  if ((DEPTH != (32'd1 << ADDR_W)) || (AUTO_CNT == 0)) begin : g_param_check
    $error("wave_capture: DEPTH must be 2**ADDR_W and AUTO_CNT nonzero");
  end

  logic [1:0]        state_q;
  logic [1:0]        state_d;
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [DEC_W-1:0]  dcnt_q;
  logic [DEC_W-1:0]  decim_lat_q;
  logic [DATA_W-1:0] prev_sample_q;
  logic              prev_valid_q;
  logic              busy_q;
  logic              cap_done_q;
  logic [DATA_W-1:0] rd_data_q;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              lvl_trig_c;
  logic              auto_hit_c;
  logic              trig_c;
  logic              we_c;
  logic [ADDR_W-1:0] wr_addr_c;

  // Upward crossing of the threshold between two consecutive valid samples.
  assign lvl_trig_c = bus.wave_data_valid_i && prev_valid_q &&
                      (prev_sample_q < trig_level_i) &&
                      (bus.wave_data_i >= trig_level_i);
  assign trig_c     = lvl_trig_c || auto_hit_c;

`ifdef WAVE_CAP_AUTO_TRIG_EN
  localparam int unsigned TO_W = $clog2(AUTO_CNT + 1);

  logic [TO_W-1:0] to_cnt_q;
  logic            auto_flag_q;
  logic            auto_trig_q;

  // The AUTO_CNT-th valid sample seen while armed forces a trigger.
  assign auto_hit_c = bus.wave_data_valid_i && (to_cnt_q == TO_W'(AUTO_CNT - 1));

  // Timeout counter runs only while armed; remembers how the frame was started.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      to_cnt_q    <= '0;
      auto_flag_q <= 1'b0;
      auto_trig_q <= 1'b0;
    end else begin
      if (state_q == ST_WAIT_TRIG) begin
        if (trig_c) begin
          to_cnt_q    <= '0;
          auto_flag_q <= !lvl_trig_c;
        end else if (bus.wave_data_valid_i) begin
          to_cnt_q <= to_cnt_q + TO_W'(1);
        end
      end else begin
        to_cnt_q <= '0;
      end
      auto_trig_q <= (state_d == ST_HOLD) && auto_flag_q;
    end
  end

  assign auto_trig_o = auto_trig_q;
`else
  assign auto_hit_c  = 1'b0;
  assign auto_trig_o = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= ST_WAIT_TRIG;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and buffer write strobe.
  always_comb begin
    state_d   = state_q;
    we_c      = 1'b0;
    wr_addr_c = wr_ptr_q;
    case (state_q)
      ST_WAIT_TRIG: begin
        if (trig_c) begin
          state_d   = ST_CAPTURE;
          we_c      = 1'b1;
          wr_addr_c = '0;
        end
      end
      ST_CAPTURE: begin
        if (bus.wave_data_valid_i && (dcnt_q == '0)) begin
          we_c = 1'b1;
          if (wr_ptr_q == LAST_ADDR) begin
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (bus.frame_done_i) begin
          state_d = ST_WAIT_TRIG;
        end
      end
      default: state_d = ST_WAIT_TRIG;
    endcase
  end

  // Write pointer, decimation, trigger history and status flags.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr_q      <= '0;
      dcnt_q        <= '0;
      decim_lat_q   <= '0;
      prev_sample_q <= '0;
      prev_valid_q  <= 1'b0;
      busy_q        <= 1'b0;
      cap_done_q    <= 1'b0;
    end else begin
      busy_q     <= (state_d == ST_CAPTURE);
      cap_done_q <= (state_d == ST_HOLD);

      if (bus.wave_data_valid_i) begin
        prev_sample_q <= bus.wave_data_i;
        prev_valid_q  <= 1'b1;
      end
      if ((state_q == ST_HOLD) && (state_d == ST_WAIT_TRIG)) begin
        prev_valid_q <= 1'b0;
      end

      if ((state_q == ST_WAIT_TRIG) && trig_c) begin
        // The trigger sample is slot 0 of the first decimation group.
        wr_ptr_q    <= ADDR_W'(1);
        decim_lat_q <= decim_i;
        dcnt_q      <= (decim_i == '0) ? '0 : DEC_W'(1);
      end else if ((state_q == ST_CAPTURE) && bus.wave_data_valid_i) begin
        dcnt_q <= (dcnt_q == decim_lat_q) ? '0 : dcnt_q + DEC_W'(1);
        if (dcnt_q == '0) begin
          wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
        end
      end
    end
  end

  // Sample buffer write port; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (rst_n_i && we_c) begin
      mem_q[wr_addr_c] <= bus.wave_data_i;
    end
  end

  // Registered display read; same-address write returns the old word.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= mem_q[bus.rd_addr_i];
    end
  end

  assign bus.rd_data_o = rd_data_q;
  assign busy_o        = busy_q;
  assign cap_done_o    = cap_done_q;

endmodule
